sd_multiphase_mod: RTL and testbench

SD_MULTIPHASE_MOD -- requirements
Module: sd_multiphase_mod

---
 rtl/sd_multiphase_mod.sv | 143 ++++++++++++++
 tb/tb_sd_multiphase_mod.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_multiphase_mod.sv
// sd_multiphase_mod: NPHASE cross-coupled second-order sigma-delta modulators
// that share one signed input level.
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   en                 advance all phases by one step (RUN state only)
//   kin/kin_valid/     input sample handshake. The first sample is applied at
//   kin_ready          once; later samples wait in a one-entry pending slot
//                      and are applied at the next frame wrap.
//   sd_out[p]          bitstream of phase p (inverted sign of stage-2 accumulator)
//   sd_valid           sd_out was updated at the last edge
//   sat_flag/clr_sat   sticky saturation indicator and its clear
module sd_multiphase_mod #(
  parameter int NPHASE   = 2,
  parameter int BITWIDTH = 32,
  parameter int POSTGAIN = 2,
  parameter int FRAME    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [BITWIDTH-1:0] kin,
  input  logic                kin_valid,
  output logic                kin_ready,
  output logic [NPHASE-1:0]   sd_out,
  output logic                sd_valid,
  output logic                sat_flag,
  input  logic                clr_sat
);
  localparam int W  = BITWIDTH;
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  // Stage-2 feedback of +/- 2^(W-2), held at the two-guard-bit sum width.
  localparam logic [W+1:0] FS_P = {{3{1'b0}}, 1'b1, {(W-2){1'b0}}};
  localparam logic [W+1:0] FS_N = {{3{1'b1}}, 1'b1, {(W-2){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [W-1:0]      k_act, pend, kneg;
  logic              pend_v, accept, adv, wrap, kneg_sat;
  logic [CW-1:0]     cnt;
  logic [NPHASE-1:0] ph_sat;

  assign kin_ready = (state_q == IDLE) | ~pend_v;
  assign accept    = kin_valid & kin_ready;
  assign adv       = (state_q == RUN) & en;
  assign wrap      = cnt == CW'(FRAME - 1);
  // -MIN is not representable; clamp it and report the saturation.
  assign kneg_sat  = k_act == SMIN;
  assign kneg      = kneg_sat ? SMAX : -k_act;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_act    <= '0;
      pend     <= '0;
      pend_v   <= 1'b0;
      cnt      <= '0;
      sd_valid <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      sd_valid <= adv;
      if (state_q == IDLE) begin
        if (accept) begin
          k_act <= kin;
          cnt   <= '0;
        end
      end else begin
        if (adv) begin
          if (wrap) begin
            cnt <= '0;
            if (pend_v) begin
              k_act  <= pend;
              pend_v <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // accept implies pend_v==0, so it never collides with the drain above
        if (accept) begin
          pend   <= kin;
          pend_v <= 1'b1;
        end
      end
      if (adv && (kneg_sat || (|ph_sat))) sat_flag <= 1'b1;
      else if (clr_sat)                   sat_flag <= 1'b0;
    end
  end

  for (genvar p = 0; p < NPHASE; p++) begin : g_ph
    localparam int PM = (p + NPHASE - 1) % NPHASE;
    localparam logic [W-1:0] RV = (p % 2 == 1) ? {W{1'b1}} : {W{1'b0}};

    logic [W-1:0]          acc, i2, x, acc_n, g, i2_n;
    logic [W+1:0]          s1, s2, step1;
    logic [W+POSTGAIN:0]   sh;
    logic                  sel, ov1, ovg, ov2;

    // Even phases take kneg when the previous phase emits 1, odd phases the
    // opposite, which cross-couples neighbouring modulators.
    assign sel   = (p % 2 == 1) ? ~sd_out[PM] : sd_out[PM];
    assign x     = sel ? kneg : k_act;
    assign step1 = sd_out[p] ? {(W+2){1'b1}} : {{(W+1){1'b0}}, 1'b1};

    // Sums carry two guard bits; overflow when the top three bits disagree.
    assign s1    = {{2{acc[W-1]}}, acc} + {{2{x[W-1]}}, x} + step1;
    assign ov1   = ~((&s1[W+1:W-1]) | ~(|s1[W+1:W-1]));
    assign acc_n = ov1 ? (s1[W+1] ? SMIN : SMAX) : s1[W-1:0];

    // Post-gain uses the pre-update acc; POSTGAIN+1 sign bits keep it exact.
    assign sh    = {{(POSTGAIN+1){acc[W-1]}}, acc} << POSTGAIN;
    assign ovg   = ~((&sh[W+POSTGAIN:W-1]) | ~(|sh[W+POSTGAIN:W-1]));
    assign g     = ovg ? (sh[W+POSTGAIN] ? SMIN : SMAX) : sh[W-1:0];

    assign s2    = {{2{i2[W-1]}}, i2} + {{2{g[W-1]}}, g} + (sd_out[p] ? FS_N : FS_P);
    assign ov2   = ~((&s2[W+1:W-1]) | ~(|s2[W+1:W-1]));
    assign i2_n  = ov2 ? (s2[W+1] ? SMIN : SMAX) : s2[W-1:0];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        acc <= RV;
        i2  <= RV;
      end else if (adv) begin
        acc <= acc_n;
        i2  <= i2_n;
      end
    end

    assign sd_out[p] = ~i2[W-1];
    assign ph_sat[p] = ov1 | ovg | ov2;
  end

endmodule

// File: tb/tb_sd_multiphase_mod.sv
// Randomized bench for sd_multiphase_mod with a longint reference model
// plus directed scenarios for start-up, frame hand-off, saturation, pause
// and asynchronous reset.
module tb_sd_multiphase_mod;
  localparam int NP = 2, W = 32, PG = 2, FR = 16;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (W-1));
  localparam longint FS   = longint'(1) << (W-2);

  logic          clk = 1'b0, reset, en, kin_valid, clr_sat;
  logic [W-1:0]  kin;
  logic          kin_ready, sd_valid, sat_flag;
  logic [NP-1:0] sd_out;

  sd_multiphase_mod #(.NPHASE(NP), .BITWIDTH(W), .POSTGAIN(PG), .FRAME(FR)) dut (
    .clk(clk), .reset(reset), .en(en), .kin(kin), .kin_valid(kin_valid),
    .kin_ready(kin_ready), .sd_out(sd_out), .sd_valid(sd_valid),
    .sat_flag(sat_flag), .clr_sat(clr_sat));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit     m_run, m_pv, m_sat, m_vld, evt;
  longint m_k, m_pend;
  int     m_cnt;
  longint m_acc[NP], m_i2[NP];

  function automatic longint clampv(longint v);
    if (v > MAXV) begin evt = 1; return MAXV; end
    if (v < MINV) begin evt = 1; return MINV; end
    return v;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_sat = 0; m_vld = 0; m_k = 0; m_pend = 0; m_cnt = 0;
    for (int p = 0; p < NP; p++) begin
      m_acc[p] = (p % 2 == 1) ? -1 : 0;
      m_i2[p]  = (p % 2 == 1) ? -1 : 0;
    end
  endtask

  function automatic logic [NP-1:0] m_sd();
    logic [NP-1:0] s;
    for (int p = 0; p < NP; p++) s[p] = (m_i2[p] >= 0);
    return s;
  endfunction

  task automatic model_step();
    bit ok, mprev;
    longint kin_s, kn, x, a_old, g;
    logic [NP-1:0] sd;
    ok = kin_valid && (!m_run || !m_pv);
    kin_s = longint'($signed(kin));
    evt = 0;
    m_vld = m_run && en;
    if (!m_run) begin
      if (ok) begin m_k = kin_s; m_cnt = 0; m_run = 1; end
    end else begin
      if (en) begin
        if (m_k == MINV) begin kn = MAXV; evt = 1; end else kn = -m_k;
        sd = m_sd();
        for (int p = 0; p < NP; p++) begin
          mprev = sd[(p + NP - 1) % NP];
          if (p % 2 == 0) x = mprev ? kn : m_k;
          else            x = mprev ? m_k : kn;
          a_old = m_acc[p];
          m_acc[p] = clampv(a_old + x + (sd[p] ? -1 : 1));
          g = clampv(a_old * (longint'(1) << PG));
          m_i2[p] = clampv(m_i2[p] + g + (sd[p] ? -FS : FS));
        end
        if (m_cnt == FR - 1) begin
          m_cnt = 0;
          if (m_pv) begin m_k = m_pend; m_pv = 0; end
        end else m_cnt++;
      end
      if (ok) begin m_pend = kin_s; m_pv = 1; end
    end
    if (evt) m_sat = 1;
    else if (clr_sat) m_sat = 0;
  endtask

  task automatic cmp_all();
    chk("sd_out", sd_out, m_sd());
    chk("sd_valid", sd_valid, m_vld);
    chk("kin_ready", kin_ready, !m_run || !m_pv);
    chk("sat_flag", sat_flag, m_sat);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; en = 0; kin_valid = 0; clr_sat = 0; kin = '0;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic load(input logic [W-1:0] v);
    kin = v; kin_valid = 1;
    tick();
    kin_valid = 0;
  endtask

  int c0, c1, n, r;
  logic [NP-1:0] held;

  initial begin
    reset = 1; en = 0; kin_valid = 0; clr_sat = 0; kin = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sd_out", sd_out, 2'b01);
    chk("rst_sd_valid", sd_valid, 0);
    chk("rst_kin_ready", kin_ready, 1);
    chk("rst_sat", sat_flag, 0);
    @(negedge clk); reset = 0;

    // start-up: first RUN edge flips 01 -> 10
    en = 1;
    load('0);
    chk("pre_run_sd", sd_out, 2'b01);
    tick();
    chk("first_run_sd", sd_out, 2'b10);
    chk("first_run_valid", sd_valid, 1);
    // 1024 RUN edges at kin=0: density near one half on both bits
    c0 = sd_out[0]; c1 = sd_out[1];
    for (int i = 1; i < 1024; i++) begin
      tick();
      c0 += sd_out[0]; c1 += sd_out[1];
    end
    chk("ones0_in_range", (c0 >= 502 && c0 <= 522), 1);
    chk("ones1_in_range", (c1 >= 502 && c1 <= 522), 1);
    chk("zero_in_no_sat", sat_flag, 0);

    // frame hand-off of a pending sample
    do_reset();
    en = 1;
    load(32'h100);
    repeat (3) tick();
    load(32'h200);
    chk("pend_full_ready", kin_ready, 0);
    n = 0;
    while (m_pv && n < 64) begin tick(); n++; end
    chk("drain_edges", n, 12);
    chk("ready_after_wrap", kin_ready, 1);

    // negative full scale: kneg clamps, sat set wins over clear
    do_reset();
    en = 1;
    load(32'h80000000);
    chk("sat_before_run", sat_flag, 0);
    tick();
    chk("sat_after_run", sat_flag, 1);
    clr_sat = 1;
    tick();
    chk("sat_set_wins", sat_flag, 1);
    en = 0;
    tick();
    chk("sat_cleared", sat_flag, 0);
    clr_sat = 0;

    // pause: state holds, handshake still fills pend
    do_reset();
    en = 1;
    load(32'h40);
    repeat (10) tick();
    held = sd_out;
    en = 0; kin = 32'h33; kin_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      kin_valid = 0;
      chk("pause_sd_hold", sd_out, held);
      chk("pause_valid", sd_valid, 0);
    end
    chk("pause_pend_full", kin_ready, 0);
    en = 1;
    repeat (20) tick();

    // randomized run with occasional asynchronous reset between edges
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 3) != 0);
      kin_valid = ($urandom_range(0, 4) == 0);
      clr_sat = ($urandom_range(0, 9) == 0);
      r = $urandom_range(0, 99);
      if (r < 3)      kin = 32'h80000000;
      else if (r < 6) kin = 32'h7fffffff;
      else            kin = 32'($urandom_range(0, 8191)) - 32'd4096;
      if ($urandom_range(0, 99) == 0) begin
        reset = 1;
        #2;
        chk("async_rst_sd", sd_out, 2'b01);
        chk("async_rst_ready", kin_ready, 1);
        chk("async_rst_valid", sd_valid, 0);
        model_reset();
        #2;
        reset = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
